acc_result_buf: RTL and testbench

Downstream stage of the convolution ALU. Captures each 20-bit signed result strobed by the ALU write-back pulse into a small show-ahead FIFO and exposes it to the APB front-end as a 32-bit sign-extended read word plus a status word. Drives an almost-full back-pressure signal to the accelerator controller so it can hold the ALU before results are lost. Keeps sticky overflow/underflow flags and a per-frame result counter.

---
 rtl/acc_pkg.sv | 17 +
 rtl/acc_rbuf_mem.sv | 22 ++
 rtl/acc_result_buf.sv | 101 ++++++++++
 tb/tb_acc_result_buf.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared constants for the convolution result buffer: data widths, status
// word bit positions and the APB register map.
package acc_pkg;
  localparam int RES_W  = 20;
  localparam int APB_DW = 32;

  localparam int ST_EMPTY   = 8;
  localparam int ST_FULL    = 9;
  localparam int ST_AFULL   = 10;
  localparam int ST_OVF     = 11;
  localparam int ST_UDF     = 12;
  localparam int ST_CNT_LSB = 16;

  localparam logic [7:0] ADDR_DATA   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_CTRL   = 8'h08;
endpackage

// File: rtl/acc_rbuf_mem.sv
// Result storage: DEPTH x W register array, synchronous write, asynchronous
// read so the FIFO head is visible without a read cycle.
module acc_rbuf_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 20,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/acc_result_buf.sv
// Show-ahead result FIFO between the convolution ALU and the APB front-end.
// Build option ACC_RBUF_RELU_EN stores negative results as zero.
module acc_result_buf
  import acc_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int RES_W    = acc_pkg::RES_W,
  parameter int AFULL_TH = 14,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb,
  input  logic [RES_W-1:0] result,
  input  logic             frame_clr,
  input  logic             pop,
  output logic [31:0]      rd_data,
  output logic [31:0]      status,
  output logic             empty,
  output logic             full,
  output logic             afull
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int CF = (CW < 5) ? CW : 5;
  localparam int FF = (CNT_W < 16) ? CNT_W : 16;

  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [CNT_W-1:0] frame_cnt;
  logic             ovf, udf;
  logic             push_ok, pop_ok;
  logic [RES_W-1:0] wdata, head;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign afull = (count >= CW'(AFULL_TH));

  // A pop frees a slot in the same edge, so a full FIFO still accepts wb+pop.
  assign pop_ok  = pop & ~empty;
  assign push_ok = wb & (~full | pop);

`ifdef ACC_RBUF_RELU_EN
  assign wdata = result[RES_W-1] ? '0 : result;
`else
  assign wdata = result;
`endif

  acc_rbuf_mem #(.DEPTH(DEPTH), .W(RES_W), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (push_ok & ~frame_clr),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_cnt <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else if (frame_clr) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      frame_cnt <= '0;
      ovf       <= 1'b0;
      udf       <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr    <= wr_ptr + AW'(1);
        frame_cnt <= frame_cnt + CNT_W'(1);
      end
      if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wb & full & ~pop) ovf <= 1'b1;
      if (pop & empty) udf <= 1'b1;
    end
  end

  assign rd_data = empty ? '0 : {{(APB_DW-RES_W){head[RES_W-1]}}, head};

  always_comb begin
    status                       = '0;
    status[CF-1:0]               = count[CF-1:0];
    status[ST_EMPTY]             = empty;
    status[ST_FULL]              = full;
    status[ST_AFULL]             = afull;
    status[ST_OVF]               = ovf;
    status[ST_UDF]               = udf;
    status[ST_CNT_LSB +: FF]     = frame_cnt[FF-1:0];
  end
endmodule

// File: tb/tb_acc_result_buf.sv
// Directed self-checking bench for acc_result_buf (default parameters).
module tb_acc_result_buf;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb = 1'b0;
  logic [19:0] result = '0;
  logic        frame_clr = 1'b0;
  logic        pop = 1'b0;
  logic [31:0] rd_data, status;
  logic        empty, full, afull;

  int vectors = 0;
  int miscompares = 0;

  acc_result_buf dut (
    .clk       (clk),
    .rst       (rst),
    .wb        (wb),
    .result    (result),
    .frame_clr (frame_clr),
    .pop       (pop),
    .rd_data   (rd_data),
    .status    (status),
    .empty     (empty),
    .full      (full),
    .afull     (afull)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_frame();
    frame_clr = 1'b1;
    tick();
    frame_clr = 1'b0;
  endtask

  task automatic push(input logic [19:0] v);
    wb = 1'b1;
    result = v;
    tick();
    wb = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    vectors++;
    if (status !== 32'h0000_0100) begin
      $display("FAIL reset_status got=%h exp=%h", status, 32'h0000_0100); miscompares++;
    end
    vectors++;
    if ({empty, full, afull} !== 3'b100) begin
      $display("FAIL reset_flags got=%b exp=%b", {empty, full, afull}, 3'b100); miscompares++;
    end
    vectors++;
    if (rd_data !== 32'h0) begin
      $display("FAIL reset_rd_data got=%h exp=%h", rd_data, 32'h0); miscompares++;
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] exp_rd [3];
    exp_rd[0] = 32'h0000_0005; exp_rd[1] = 32'hFFFF_FFFD; exp_rd[2] = 32'h0007_FFFF;
    push(20'h00005);
    push(20'hFFFFD);
    push(20'h7FFFF);
    vectors++;
    if (status !== 32'h0003_0003) begin
      $display("FAIL basic_status got=%h exp=%h", status, 32'h0003_0003); miscompares++;
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (rd_data !== exp_rd[i]) begin
        $display("FAIL basic_pop%0d got=%h exp=%h", i, rd_data, exp_rd[i]); miscompares++;
      end
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
    vectors++;
    if (rd_data !== 32'h0 || empty !== 1'b1) begin
      $display("FAIL basic_drained rd_data=%h empty=%b exp 0/1", rd_data, empty); miscompares++;
    end
  endtask

  task automatic test_full_overflow();
    clear_frame();
    for (int i = 1; i <= 13; i++) push(20'(i));
    vectors++;
    if (afull !== 1'b0) begin
      $display("FAIL afull_at13 got=%b exp=0", afull); miscompares++;
    end
    push(20'd14);
    vectors++;
    if (afull !== 1'b1 || full !== 1'b0) begin
      $display("FAIL afull_at14 afull=%b full=%b exp 1/0", afull, full); miscompares++;
    end
    push(20'd15);
    push(20'd16);
    vectors++;
    if (full !== 1'b1) begin
      $display("FAIL full_at16 got=%b exp=1", full); miscompares++;
    end
    push(20'd17);
    vectors++;
    if (status !== 32'h0010_0E10) begin
      $display("FAIL overflow_status got=%h exp=%h", status, 32'h0010_0E10); miscompares++;
    end
    vectors++;
    if (rd_data !== 32'h0000_0001) begin
      $display("FAIL overflow_head got=%h exp=%h", rd_data, 32'h1); miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    clear_frame();
    for (int i = 0; i < 16; i++) push(20'(32'h100 + i));
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if (rd_data !== 32'h100 + 32'(k)) begin
        $display("FAIL b2b_head%0d got=%h exp=%h", k, rd_data, 32'h100 + 32'(k)); miscompares++;
      end
      wb = 1'b1; pop = 1'b1; result = 20'(32'h200 + k);
      tick();
    end
    wb = 1'b0; pop = 1'b0;
    vectors++;
    if (status !== 32'h0015_0610) begin
      $display("FAIL b2b_status got=%h exp=%h", status, 32'h0015_0610); miscompares++;
    end
    for (int i = 0; i < 16; i++) begin
      exp = (i < 11) ? 32'h105 + 32'(i) : 32'h200 + 32'(i - 11);
      vectors++;
      if (rd_data !== exp) begin
        $display("FAIL b2b_order%0d got=%h exp=%h", i, rd_data, exp); miscompares++;
      end
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
    vectors++;
    if (empty !== 1'b1) begin
      $display("FAIL b2b_empty got=%b exp=1", empty); miscompares++;
    end
  endtask

  task automatic test_underflow();
    clear_frame();
    wb = 1'b1; pop = 1'b1; result = 20'h00010;
    tick();
    wb = 1'b0; pop = 1'b0;
    vectors++;
    if (status !== 32'h0001_1001) begin
      $display("FAIL underflow_status got=%h exp=%h", status, 32'h0001_1001); miscompares++;
    end
    vectors++;
    if (rd_data !== 32'h0000_0010) begin
      $display("FAIL underflow_rd_data got=%h exp=%h", rd_data, 32'h10); miscompares++;
    end
  endtask

  task automatic test_frame_clr();
    for (int i = 0; i < 6; i++) push(20'(i + 1));
    vectors++;
    if (status !== 32'h0007_1007) begin
      $display("FAIL preclr_status got=%h exp=%h", status, 32'h0007_1007); miscompares++;
    end
    frame_clr = 1'b1; wb = 1'b1; pop = 1'b1; result = 20'h00055;
    tick();
    frame_clr = 1'b0; wb = 1'b0; pop = 1'b0;
    vectors++;
    if (status !== 32'h0000_0100) begin
      $display("FAIL frame_clr_status got=%h exp=%h", status, 32'h0000_0100); miscompares++;
    end
    vectors++;
    if (rd_data !== 32'h0) begin
      $display("FAIL frame_clr_rd_data got=%h exp=%h", rd_data, 32'h0); miscompares++;
    end
  endtask

  task automatic test_sign();
    logic [31:0] exp_neg;
`ifdef ACC_RBUF_RELU_EN
    exp_neg = 32'h0000_0000;
`else
    exp_neg = 32'hFFF8_0000;
`endif
    clear_frame();
    push(20'h80000);
    push(20'h00003);
    vectors++;
    if (rd_data !== exp_neg) begin
      $display("FAIL sign_first got=%h exp=%h", rd_data, exp_neg); miscompares++;
    end
    pop = 1'b1; tick(); pop = 1'b0;
    vectors++;
    if (rd_data !== 32'h0000_0003) begin
      $display("FAIL sign_second got=%h exp=%h", rd_data, 32'h3); miscompares++;
    end
    pop = 1'b1; tick(); pop = 1'b0;
  endtask

  task automatic test_async_reset();
    push(20'h00021);
    push(20'h00022);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (status !== 32'h0000_0100 || rd_data !== 32'h0) begin
      $display("FAIL async_reset status=%h rd_data=%h exp 00000100/0", status, rd_data); miscompares++;
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_overflow();
    test_back_to_back();
    test_underflow();
    test_frame_clr();
    test_sign();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
